seg7_monitor: RTL and testbench

SEG7_MONITOR -- requirements
Module: seg7_monitor

---
 rtl/seg7_pkg.sv | 29 ++
 rtl/seg7_monitor_if.sv | 30 +++
 rtl/seg7_decode.sv | 24 ++
 rtl/seg7_monitor.sv | 134 +++++++++++++
 tb/tb_seg7_monitor.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment monitor.
// Segment bit order is {g,f,e,d,c,b,a}.
package seg7_pkg;

    localparam int unsigned DIGITS = 16;
    localparam logic [6:0] BLANK = 7'h00;

    localparam logic [6:0] SEG_TABLE [DIGITS] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F,
        7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C,
        7'h39, 7'h5E, 7'h79, 7'h71
    };

    typedef enum logic {
        EMPTY = 1'b0,
        TRACK = 1'b1
    } state_t;

    typedef struct packed {
        logic valid;
        logic err;
        logic up;
        logic down;
        logic jump;
        logic wrap;
    } pulse_t;

endpackage

// File: rtl/seg7_monitor_if.sv
// Sampling controls and monitor results of seg7_monitor.
// master drives the pattern; slave is the monitor.
interface seg7_monitor_if;

    logic       en;
    logic       clear;
    logic [6:0] seg_in;
    logic [3:0] value;
    logic       locked;
    logic       value_valid;
    logic       err_invalid;
    logic       step_up;
    logic       step_down;
    logic       jump;
    logic       wrap;
    logic [7:0] step_count;

    modport master (
        output en, clear, seg_in,
        input  value, locked, value_valid, err_invalid,
        input  step_up, step_down, jump, wrap, step_count
    );

    modport slave (
        input  en, clear, seg_in,
        output value, locked, value_valid, err_invalid,
        output step_up, step_down, jump, wrap, step_count
    );

endinterface

// File: rtl/seg7_decode.sv
// Combinational seven-segment pattern decoder.
// BLANK is reported separately and is not a valid digit.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [6:0] seg_in,
    output logic [3:0] digit,
    output logic       is_valid,
    output logic       is_blank
);

    always_comb begin
        digit    = 4'd0;
        is_valid = 1'b0;
        is_blank = (seg_in == BLANK);
        for (int i = 0; i < DIGITS; i++) begin
            if (seg_in == SEG_TABLE[i]) begin
                digit    = 4'(i);
                is_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_monitor.sv
// Debounces a segment pattern, decodes it and classifies
// successive digits as steps, jumps and wraps.
module seg7_monitor
    import seg7_pkg::*;
#(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic         clk_2,
    input  logic         reset_n,
    seg7_monitor_if.slave bus
);

    localparam logic [3:0] N = 4'(STABLE_CYCLES);

    logic [6:0] sample;
    logic [6:0] prev;
    logic [3:0] cnt;
    logic [3:0] cnt_nx;
    logic [3:0] cnt_inc;
    logic       same;
    logic       accept;

    state_t     state;
    state_t     state_nx;
    logic [3:0] value;
    logic [3:0] value_nx;
    logic [7:0] count;
    logic [7:0] count_nx;
    pulse_t     pulse;
    pulse_t     pulse_nx;

    logic [3:0] digit;
    logic       is_valid;
    logic       is_blank;
    logic [3:0] diff;

    seg7_decode u_decode (
        .seg_in  (sample),
        .digit   (digit),
        .is_valid(is_valid),
        .is_blank(is_blank)
    );

    // The counter tracks the registered sample, hence the extra edge.
    assign same    = (sample == prev);
    assign cnt_inc = !same ? 4'd1 :
                     (cnt == 4'hF) ? cnt : cnt + 4'd1;
    assign accept  = bus.en && !bus.clear && (cnt_inc == N)
                     && !(same && cnt == N);
    assign diff    = digit - value;

    always_comb begin
        state_nx = state;
        value_nx = value;
        count_nx = count;
        cnt_nx   = cnt;
        pulse_nx = '0;
        if (bus.clear) begin
            state_nx = EMPTY;
            value_nx = 4'd0;
            count_nx = 8'd0;
            cnt_nx   = 4'd0;
        end else if (bus.en) begin
            cnt_nx = cnt_inc;
            if (accept) begin
                unique case (1'b1)
                    is_blank: begin
                        state_nx = EMPTY;
                    end
                    !is_valid && !is_blank: begin
                        pulse_nx.err = 1'b1;
                    end
                    is_valid && state == EMPTY: begin
                        state_nx       = TRACK;
                        value_nx       = digit;
                        pulse_nx.valid = 1'b1;
                    end
                    default: begin
                        if (diff != 4'd0) begin
                            value_nx       = digit;
                            pulse_nx.valid = 1'b1;
                            if (diff == 4'd1) begin
                                pulse_nx.up   = 1'b1;
                                pulse_nx.wrap = (value == 4'hF);
                            end else if (diff == 4'hF) begin
                                pulse_nx.down = 1'b1;
                                pulse_nx.wrap = (value == 4'h0);
                            end else begin
                                pulse_nx.jump = 1'b1;
                            end
                            if ((pulse_nx.up || pulse_nx.down)
                                && count != 8'hFF) begin
                                count_nx = count + 8'd1;
                            end
                        end
                    end
                endcase
            end
        end
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            sample <= 7'd0;
            prev   <= 7'd0;
            cnt    <= 4'd0;
            state  <= EMPTY;
            value  <= 4'd0;
            count  <= 8'd0;
            pulse  <= '0;
        end else begin
            if (bus.en) begin
                sample <= bus.seg_in;
                prev   <= sample;
            end
            cnt   <= cnt_nx;
            state <= state_nx;
            value <= value_nx;
            count <= count_nx;
            pulse <= pulse_nx;
        end
    end

    assign bus.value       = value;
    assign bus.locked      = (state == TRACK);
    assign bus.value_valid = pulse.valid;
    assign bus.err_invalid = pulse.err;
    assign bus.step_up     = pulse.up;
    assign bus.step_down   = pulse.down;
    assign bus.jump        = pulse.jump;
    assign bus.wrap        = pulse.wrap;
    assign bus.step_count  = count;

endmodule

// File: tb/tb_seg7_monitor.sv
// Directed and random checks of seg7_monitor against an
// episode-length reference model.
module tb_seg7_monitor;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    seg7_monitor_if bus ();

    seg7_monitor #(.STABLE_CYCLES(N)) dut (
        .clk_2  (clk),
        .reset_n(rst_n),
        .bus    (bus)
    );

    logic [6:0] tbl [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    int total = 0;
    int bad = 0;

    // reference model state
    logic [6:0] m_cur, m_prv;
    int m_len, m_val, m_cnt;
    bit m_lock;
    bit e_vv, e_err, e_up, e_dn, e_jmp, e_wrap;

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic int dig_of(logic [6:0] p);
        if (p == 7'h00) return 16;
        for (int i = 0; i < 16; i++)
            if (tbl[i] == p) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_cur = 7'h00; m_prv = 7'h00;
        m_len = 0; m_val = 0; m_cnt = 0; m_lock = 0;
        {e_vv, e_err, e_up, e_dn, e_jmp, e_wrap} = '0;
    endtask

    task automatic model_accept(logic [6:0] p);
        int d, df;
        d = dig_of(p);
        if (d < 0) e_err = 1;
        else if (d == 16) m_lock = 0;
        else if (!m_lock) begin
            m_lock = 1; m_val = d; e_vv = 1;
        end else begin
            df = (d - m_val + 16) % 16;
            if (df != 0) begin
                e_vv = 1;
                if (df == 1) begin
                    e_up = 1; e_wrap = (m_val == 15);
                end else if (df == 15) begin
                    e_dn = 1; e_wrap = (m_val == 0);
                end else e_jmp = 1;
                if (df == 1 || df == 15)
                    m_cnt = (m_cnt >= 255) ? 255 : m_cnt + 1;
                m_val = d;
            end
        end
    endtask

    task automatic model_edge(logic [6:0] seg, bit en, bit clr);
        {e_vv, e_err, e_up, e_dn, e_jmp, e_wrap} = '0;
        if (clr) begin
            m_len = 0; m_val = 0; m_cnt = 0; m_lock = 0;
        end else if (en) begin
            m_len = (m_cur == m_prv) ? m_len + 1 : 1;
            if (m_len == N) model_accept(m_cur);
        end
        if (en) begin
            m_prv = m_cur; m_cur = seg;
        end
    endtask

    task automatic check_all();
        chk("value", bus.value, m_val);
        chk("locked", bus.locked, m_lock);
        chk("value_valid", bus.value_valid, e_vv);
        chk("err_invalid", bus.err_invalid, e_err);
        chk("step_up", bus.step_up, e_up);
        chk("step_down", bus.step_down, e_dn);
        chk("jump", bus.jump, e_jmp);
        chk("wrap", bus.wrap, e_wrap);
        chk("step_count", bus.step_count, m_cnt);
    endtask

    task automatic step(logic [6:0] seg, bit en, bit clr);
        bus.seg_in = seg; bus.en = en; bus.clear = clr;
        model_edge(seg, en, clr);
        @(posedge clk);
        #1;
        check_all();
    endtask

    task automatic hold(logic [6:0] seg, int n);
        repeat (n) step(seg, 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        model_reset();
        check_all();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int cnt_save, len;
        logic [6:0] p;
        bus.en = 1'b0; bus.clear = 1'b0; bus.seg_in = 7'h00;
        model_reset();
        #12;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // first digit from EMPTY: pulse on the fifth edge
        hold(7'h3F, 4);
        chk("r33_pre_valid", bus.value_valid, 1'b0);
        hold(7'h3F, 1);
        chk("r33_valid", bus.value_valid, 1'b1);
        chk("r33_lock", bus.locked, 1'b1);
        hold(7'h3F, 2);

        hold(7'h06, 6);
        hold(7'h5B, 6);
        chk("r34_count", bus.step_count, 8'd2);
        chk("r34_value", bus.value, 4'd2);

        hold(7'h71, 6);
        hold(7'h3F, 6);
        hold(7'h71, 6);
        chk("r35_value", bus.value, 4'hF);

        hold(7'h7F, 3);
        hold(7'h12, 5);
        chk("r36_value", bus.value, 4'hF);

        cnt_save = int'(bus.step_count);
        hold(7'h5B, 6);
        chk("r37_count", bus.step_count, cnt_save);
        hold(7'h00, 6);
        chk("r37_lock", bus.locked, 1'b0);
        chk("r37_value", bus.value, 4'd2);

        // clear on the acceptance edge wins
        hold(7'h3F, 4);
        step(7'h3F, 1'b1, 1'b1);
        chk("r38_clr_lock", bus.locked, 1'b0);
        hold(7'h3F, 4);

        // reset mid-episode, then fresh EMPTY acceptance
        hold(7'h06, 3);
        do_reset();
        hold(7'h06, 6);
        chk("r38_rst_lock", bus.locked, 1'b1);
        chk("r38_rst_count", bus.step_count, 8'd0);

        // en low freezes an episode
        hold(7'h5B, 2);
        repeat (3) step(7'h5B, 1'b0, 1'b0);
        hold(7'h5B, 4);

        // saturate the step counter
        for (int i = 0; i < 130; i++) begin
            hold(7'h3F, 5);
            hold(7'h06, 5);
        end
        chk("sat_count", bus.step_count, 8'd255);

        for (int i = 0; i < 300; i++) begin
            case ($urandom_range(0, 5))
                0: p = 7'h00;
                1: p = 7'($urandom_range(0, 127));
                default: p = tbl[$urandom_range(0, 15)];
            endcase
            len = $urandom_range(1, 7);
            repeat (len)
                step(p, ($urandom_range(0, 7) != 0),
                     ($urandom_range(0, 59) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
